cart_mem_loader: RTL and testbench

CART_MEM_LOADER -- requirements
Module: cart_mem_loader

---
 rtl/cart_pkg.sv | 36 +++
 rtl/cart_lane_mux.sv | 33 +++
 rtl/cart_mem_loader.sv | 162 ++++++++++++++++
 tb/tb_cart_mem_loader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared definitions for the cartridge memory loader.
// Holds the loader state encoding, the CPU region decode type and the word-space layout helpers:
// PRG sits at word 0, CHR directly after PRG, cart RAM directly after CHR. Only PRG and CHR are
// copied from flash, so the load length equals the RAM base.
package cart_pkg;

  typedef enum logic [0:0] {
    StLoad,
    StReady
  } cart_state_e;

  typedef enum logic [1:0] {
    RegNone,
    RegPrg,
    RegChr,
    RegRam
  } cart_region_e;

  // Word base of the CHR region (PRG size in 32-bit words).
  function automatic int unsigned chr_word_base(input int unsigned prg_log2);
    return 32'd1 << (prg_log2 - 2);
  endfunction

  // Word base of the cart RAM region (PRG + CHR size in words).
  function automatic int unsigned ram_word_base(input int unsigned prg_log2,
                                                input int unsigned chr_log2);
    return (32'd1 << (prg_log2 - 2)) + (32'd1 << (chr_log2 - 2));
  endfunction

  // Number of 32-bit words copied from flash on every load.
  function automatic int unsigned load_words(input int unsigned prg_log2,
                                             input int unsigned chr_log2);
    return ram_word_base(prg_log2, chr_log2);
  endfunction

endpackage

// File: rtl/cart_lane_mux.sv
// Byte-lane steering between the 8-bit CPU bus and the 32-bit backing memory.
// Ports:
//   wr_lane_i  byte lane of the write (address[1:0])
//   wr_byte_i  CPU write byte
//   wdata_o    write byte replicated on all four lanes
//   wen_o      one-hot byte enable for wr_lane_i
//   rd_lane_i  byte lane of the pending read
//   rd_word_i  memory read word
//   rd_byte_o  selected byte of rd_word_i
module cart_lane_mux (
  input  logic [1:0]  wr_lane_i,
  input  logic [7:0]  wr_byte_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wen_o,
  input  logic [1:0]  rd_lane_i,
  input  logic [31:0] rd_word_i,
  output logic [7:0]  rd_byte_o
);

  always_comb begin
    wdata_o = {4{wr_byte_i}};
    wen_o   = 4'b0001 << wr_lane_i;
    rd_byte_o = rd_word_i[7:0];
    unique case (rd_lane_i)
      2'd0: rd_byte_o = rd_word_i[7:0];
      2'd1: rd_byte_o = rd_word_i[15:8];
      2'd2: rd_byte_o = rd_word_i[23:16];
      2'd3: rd_byte_o = rd_word_i[31:24];
      default: rd_byte_o = rd_word_i[7:0];
    endcase
  end

endmodule

// File: rtl/cart_mem_loader.sv
// Cartridge memory loader: copies the PRG+CHR image of the selected flash slot into a 32-bit
// backing memory, then serves byte-wide CPU reads/writes to the PRG, CHR and cart RAM regions.
// Ports:
//   clock, reset         clock; synchronous active-high reset (restarts the load)
//   reload, index        restart load; image slot (latched on reset and reload only)
//   cart_ready           image fully loaded, CPU accesses enabled
//   address, *_sel       CPU byte offset within region; region selects (prg > chr > ram)
//   rden, wren           CPU read/write strobes
//   write_data           CPU write byte
//   read_data/read_valid read byte (held between reads); pulses the cycle after rden
//   flash_*              word-read handshake to the external SPI flash engine
//   mem_*                backing memory port, 1-cycle read latency, read-before-write
module cart_mem_loader
  import cart_pkg::*;
#(
  parameter int unsigned MEM_AW     = 15,
  parameter int unsigned PRG_LOG2   = 16,
  parameter int unsigned CHR_LOG2   = 15,
  parameter int unsigned RAM_LOG2   = 13,
  parameter int unsigned IDX_W      = 4,
  parameter logic [23:0] FLASH_BASE = 24'h100000,
  parameter int unsigned SLOT_LOG2  = 17,
  parameter bit          ROM_WP     = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reload,
  input  logic [IDX_W-1:0]  index,
  output logic              cart_ready,
  input  logic [20:0]       address,
  input  logic              prg_sel,
  input  logic              chr_sel,
  input  logic              ram_sel,
  input  logic              rden,
  input  logic              wren,
  input  logic [7:0]        write_data,
  output logic [7:0]        read_data,
  output logic              read_valid,
  output logic              flash_valid,
  input  logic              flash_ready,
  output logic [23:0]       flash_addr,
  input  logic [31:0]       flash_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_wen,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [MEM_AW-1:0] ChrBase  = MEM_AW'(chr_word_base(PRG_LOG2));
  localparam logic [MEM_AW-1:0] RamBase  = MEM_AW'(ram_word_base(PRG_LOG2, CHR_LOG2));
  localparam logic [MEM_AW-1:0] LastWord = MEM_AW'(load_words(PRG_LOG2, CHR_LOG2) - 1);

  cart_state_e       state_q, state_d;
  logic [MEM_AW-1:0] load_addr_q, load_addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rd_pend_q, rd_pend_d;
  logic [1:0]        lane_q, lane_d;
  logic [7:0]        read_data_q;

  cart_region_e      region;
  logic [MEM_AW-1:0] cpu_addr;
  logic              cpu_hit, cpu_wr, load_accept;
  logic [31:0]       lane_wdata;
  logic [3:0]        lane_wen;
  logic [7:0]        rd_byte;

  // Bits above the largest region are don't-care (offset is taken modulo region size).
  logic unused_addr;
  assign unused_addr = ^address;

  cart_lane_mux u_lane_mux (
    .wr_lane_i (address[1:0]),
    .wr_byte_i (write_data),
    .wdata_o   (lane_wdata),
    .wen_o     (lane_wen),
    .rd_lane_i (lane_q),
    .rd_word_i (mem_rdata),
    .rd_byte_o (rd_byte)
  );

  always_comb begin
    region = RegNone;
    if (prg_sel) begin
      region = RegPrg;
    end else if (chr_sel) begin
      region = RegChr;
    end else if (ram_sel) begin
      region = RegRam;
    end
  end

  always_comb begin
    cpu_addr = '0;
    case (region)
      RegPrg:  cpu_addr = MEM_AW'(address[PRG_LOG2-1:2]);
      RegChr:  cpu_addr = ChrBase + MEM_AW'(address[CHR_LOG2-1:2]);
      RegRam:  cpu_addr = RamBase + MEM_AW'(address[RAM_LOG2-1:2]);
      default: cpu_addr = '0;
    endcase
  end

  always_comb begin
    // A reload cycle already belongs to the new load: CPU strobes and flash data are dropped.
    load_accept = (state_q == StLoad) && !reset && !reload && flash_ready;
    cpu_hit     = (state_q == StReady) && !reset && !reload && (region != RegNone);
    cpu_wr      = cpu_hit && wren && ((region == RegRam) || !ROM_WP);

    state_d     = state_q;
    load_addr_d = load_addr_q;
    idx_d       = idx_q;
    rd_pend_d   = cpu_hit && rden;
    lane_d      = (cpu_hit && rden) ? address[1:0] : lane_q;

    if (reload) begin
      state_d     = StLoad;
      load_addr_d = '0;
      idx_d       = index;
    end else if (load_accept) begin
      if (load_addr_q == LastWord) begin
        state_d     = StReady;
        load_addr_d = '0;
      end else begin
        load_addr_d = load_addr_q + MEM_AW'(1);
      end
    end
  end

  always_comb begin
    flash_valid = (state_q == StLoad) && !reset;
    flash_addr  = FLASH_BASE + (24'(idx_q) << SLOT_LOG2) + 24'({load_addr_q, 2'b00});
    cart_ready  = (state_q == StReady);
    read_valid  = rd_pend_q;
    read_data   = rd_pend_q ? rd_byte : read_data_q;
    mem_addr    = (state_q == StLoad) ? load_addr_q : cpu_addr;
    mem_wdata   = (state_q == StLoad) ? flash_rdata : lane_wdata;
    mem_wen     = 4'b0000;
    if (load_accept) begin
      mem_wen = 4'b1111;
    end else if (cpu_wr) begin
      mem_wen = lane_wen;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StLoad;
      load_addr_q <= '0;
      idx_q       <= index;
      rd_pend_q   <= 1'b0;
      lane_q      <= 2'd0;
      read_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      idx_q       <= idx_d;
      rd_pend_q   <= rd_pend_d;
      lane_q      <= lane_d;
      read_data_q <= read_data;
    end
  end

endmodule

// File: tb/tb_cart_mem_loader.sv
// Bench for cart_mem_loader: directed stimulus, a behavioural model checked every cycle, and
// hand-computed literal expectations for the key scenarios.
module tb_cart_mem_loader;

  localparam int LOAD_WORDS = (65536 + 32768) / 4;

  logic        clock = 1'b0;
  logic        reset, reload;
  logic [3:0]  index;
  logic        cart_ready;
  logic [20:0] address;
  logic        prg_sel, chr_sel, ram_sel, rden, wren;
  logic [7:0]  write_data, read_data;
  logic        read_valid, flash_valid, flash_ready;
  logic [23:0] flash_addr;
  logic [31:0] flash_rdata;
  logic [14:0] mem_addr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  cart_mem_loader dut (
    .clock(clock), .reset(reset), .reload(reload), .index(index), .cart_ready(cart_ready),
    .address(address), .prg_sel(prg_sel), .chr_sel(chr_sel), .ram_sel(ram_sel),
    .rden(rden), .wren(wren), .write_data(write_data), .read_data(read_data),
    .read_valid(read_valid), .flash_valid(flash_valid), .flash_ready(flash_ready),
    .flash_addr(flash_addr), .flash_rdata(flash_rdata), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Flash returns its own byte address as data.
  assign flash_rdata = {8'h00, flash_addr};

  // Backing memory: read-before-write, 1-cycle latency.
  logic [31:0] env_mem [0:32767];
  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_wen[i]) env_mem[mem_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
    end
    mem_rdata <= env_mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] exp_mem [0:32767];
  bit          m_valid = 0;
  bit          m_loading;
  int          m_cnt;
  logic [3:0]  m_idx;
  bit          m_rd_pend;
  logic [7:0]  m_rd_exp, m_last;

  initial begin
    for (int i = 0; i < 32768; i++) begin
      env_mem[i] = 32'h0;
      exp_mem[i] = 32'h0;
    end
  end

  function automatic int region_of(input logic p, input logic c, input logic r);
    if (p) return 1;
    if (c) return 2;
    if (r) return 3;
    return 0;
  endfunction

  function automatic int word_of(input int k, input logic [20:0] a);
    int ai;
    ai = int'(a);
    if (k == 1) return (ai % 65536) / 4;
    if (k == 2) return 16384 + (ai % 32768) / 4;
    return 24576 + (ai % 8192) / 4;
  endfunction

  always @(negedge clock) begin : model
    logic [3:0]  e_wen;
    logic [14:0] e_addr;
    logic [31:0] e_wdata;
    logic [23:0] fa;
    int          k, wa, lane;
    e_wen = 4'h0;
    e_addr = '0;
    e_wdata = '0;
    if (reset) begin
      check("rst_flash_valid", flash_valid, 1'b0);
      check("rst_mem_wen", mem_wen, 4'h0);
      m_loading = 1; m_cnt = 0; m_idx = index; m_rd_pend = 0; m_last = 8'h00; m_valid = 1;
    end else if (m_valid) begin
      fa = 24'h100000 + 24'(m_idx) * 24'h20000 + 24'(4 * m_cnt);
      check("read_valid", read_valid, m_rd_pend);
      if (m_rd_pend) m_last = m_rd_exp;
      check("read_data", read_data, m_last);
      check("cart_ready", cart_ready, !m_loading);
      check("flash_valid", flash_valid, m_loading);
      if (m_loading) check("flash_addr", flash_addr, fa);
      m_rd_pend = 0;
      if (reload) begin
        m_loading = 1; m_cnt = 0; m_idx = index;
      end else if (m_loading) begin
        if (flash_ready) begin
          e_wen = 4'hF; e_addr = 15'(m_cnt); e_wdata = {8'h00, fa};
          exp_mem[m_cnt] = {8'h00, fa};
          m_cnt++;
          if (m_cnt == LOAD_WORDS) m_loading = 0;
        end
      end else begin
        k = region_of(prg_sel, chr_sel, ram_sel);
        if (k != 0) begin
          wa = word_of(k, address);
          lane = int'(address[1:0]);
          if (rden) begin
            m_rd_pend = 1;
            m_rd_exp = exp_mem[wa][lane*8 +: 8];
          end
          if (wren && k == 3) begin
            e_wen = 4'(1 << lane); e_addr = 15'(wa); e_wdata = {4{write_data}};
            exp_mem[wa][lane*8 +: 8] = write_data;
          end
        end
      end
      check("mem_wen", mem_wen, e_wen);
      if (e_wen != 4'h0) begin
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic run_load(input logic [23:0] base, output int acc, output bit done);
    bit probed;
    acc = 0; done = 0; probed = 0;
    for (int c = 0; c < 40000 && !done; c++) begin
      flash_ready = (c % 5) != 4;
      @(negedge clock);
      if (cart_ready) begin
        done = 1;
      end else begin
        if (!probed && acc == 5000) begin
          check("mid_load_flash_addr", flash_addr, base + 24'd20000);
          probed = 1;
        end
        if (flash_valid && flash_ready) acc++;
      end
      next_cycle();
    end
    flash_ready = 0;
  endtask

  task automatic access(input logic [2:0] sel, input logic [20:0] a, input bit rd, input bit wr,
                        input logic [7:0] d, output logic [3:0] wen, output logic [14:0] maddr,
                        output logic [31:0] wd, output logic rv, output logic [7:0] rdat);
    {prg_sel, chr_sel, ram_sel} = sel;
    address = a; rden = rd; wren = wr; write_data = d;
    @(negedge clock);
    wen = mem_wen; maddr = mem_addr; wd = mem_wdata;
    next_cycle();
    {prg_sel, chr_sel, ram_sel} = 3'b000;
    rden = 0; wren = 0;
    @(negedge clock);
    rv = read_valid; rdat = read_data;
    next_cycle();
  endtask

  localparam logic [2:0] PRG = 3'b100, CHR = 3'b010, RAM = 3'b001, NONE = 3'b000;

  initial begin : stim
    int acc;
    bit done;
    logic [3:0] wen;
    logic [14:0] maddr;
    logic [31:0] wd;
    logic rv;
    logic [7:0] rdat;

    reset = 1; reload = 0; index = 4'd3; flash_ready = 0;
    address = '0; prg_sel = 0; chr_sel = 0; ram_sel = 0; rden = 0; wren = 0; write_data = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    @(negedge clock);
    check("first_flash_valid", flash_valid, 1'b1);
    check("first_flash_addr", flash_addr, 24'h160000);
    check("load_cart_ready", cart_ready, 1'b0);
    next_cycle();

    // Partial load, then reset mid-load restarts from word 0.
    flash_ready = 1;
    repeat (10) next_cycle();
    reset = 1;
    @(negedge clock);
    check("midrst_flash_valid", flash_valid, 1'b0);
    check("midrst_mem_wen", mem_wen, 4'h0);
    next_cycle();
    reset = 0; flash_ready = 0;
    @(negedge clock);
    check("midrst_restart_addr", flash_addr, 24'h160000);
    next_cycle();

    index = 4'd9;  // not latched: no reset/reload
    run_load(24'h160000, acc, done);
    check("load1_done", done, 1'b1);
    check("load1_accepts", acc, LOAD_WORDS);

    access(PRG, 21'h0006, 1, 0, 8'h00, wen, maddr, wd, rv, rdat);
    check("prg_rd_valid", rv, 1'b1);
    check("prg_rd_data", rdat, 8'h16);
    @(negedge clock);
    check("hold_valid", read_valid, 1'b0);
    check("hold_data", read_data, 8'h16);
    next_cycle();

    access(CHR, 21'h0004, 0, 1, 8'hA5, wen, maddr, wd, rv, rdat);
    check("chr_wp_wen", wen, 4'h0);
    access(RAM, 21'h1FFF, 0, 1, 8'hA5, wen, maddr, wd, rv, rdat);
    check("ram_top_wen", wen, 4'b1000);
    check("ram_top_addr", maddr, 15'h67FF);
    check("ram_top_wdata", wd, 32'hA5A5A5A5);
    access(RAM, 21'h0010, 0, 1, 8'h5A, wen, maddr, wd, rv, rdat);
    check("ram_5a_wen", wen, 4'b0001);
    access(RAM, 21'h0020, 1, 1, 8'h77, wen, maddr, wd, rv, rdat);
    check("rdwr_wen", wen, 4'b0001);
    check("rdwr_old_data", rdat, 8'h00);
    access(RAM, 21'h0020, 1, 0, 8'h00, wen, maddr, wd, rv, rdat);
    check("rdwr_new_data", rdat, 8'h77);
    access(CHR, 21'h8006, 1, 0, 8'h00, wen, maddr, wd, rv, rdat);
    check("chr_wrap_data", rdat, 8'h17);
    access(PRG, 21'h10006, 1, 0, 8'h00, wen, maddr, wd, rv, rdat);
    check("prg_wrap_data", rdat, 8'h16);
    access(NONE, 21'h0006, 1, 0, 8'h00, wen, maddr, wd, rv, rdat);
    check("nosel_rd_valid", rv, 1'b0);
    access(RAM, 21'h1FFF, 1, 0, 8'h00, wen, maddr, wd, rv, rdat);
    check("ram_top_rd", rdat, 8'hA5);

    // Reload with a new slot, interrupt it at word 100 with a coincident flash_ready.
    index = 4'd5; reload = 1;
    next_cycle();
    reload = 0; flash_ready = 1;
    acc = 0;
    for (int c = 0; c < 200 && acc < 100; c++) begin
      @(negedge clock);
      if (c == 0) check("reload_first_addr", flash_addr, 24'h1A0000);
      if (flash_valid) acc++;
      next_cycle();
    end
    check("reload_reached_100", acc, 100);
    reload = 1;
    @(negedge clock);
    check("reload100_addr", flash_addr, 24'h1A0190);
    check("reload100_no_write", mem_wen, 4'h0);
    next_cycle();
    reload = 0; flash_ready = 0;
    @(negedge clock);
    check("reload100_restart", flash_addr, 24'h1A0000);
    next_cycle();
    run_load(24'h1A0000, acc, done);
    check("load2_done", done, 1'b1);
    check("load2_accepts", acc, LOAD_WORDS);

    access(RAM, 21'h0010, 1, 0, 8'h00, wen, maddr, wd, rv, rdat);
    check("ram_survives", rdat, 8'h5A);
    access(PRG, 21'h0006, 1, 0, 8'h00, wen, maddr, wd, rv, rdat);
    check("slot5_prg_data", rdat, 8'h1A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
